uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_pkg.sv | 28 ++
 rtl/uart_cmd_if.sv | 23 ++
 rtl/uart_cmd_ack.sv | 40 ++++
 rtl/uart_cmd_parser.sv | 116 +++++++++++
 tb/tb_uart_cmd_parser.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART command parser: FSM states, ASCII constants
// and the acknowledge sequencer state.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDigits  = 2'd1,
        StDiscard = 2'd2
    } state_t;

    // Which acknowledge byte is currently presented to the transmitter.
    typedef enum logic {
        AckChar    = 1'b0,
        AckNewline = 1'b1
    } ack_state_t;

    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/uart_cmd_if.sv
// Byte-stream / command bus between the UART receiver, the parser and the
// UART transmitter. The parser uses the slave modport.
interface uart_cmd_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cmd_valid;
    logic [7:0] cmd_angle;
    logic [15:0] cmd_pulse;
    logic       cmd_error;
    logic       ack_tx_valid;
    logic [7:0] ack_tx_data;
    logic       ack_tx_ready;

    modport master (
        output rx_valid, rx_data, ack_tx_ready,
        input  cmd_valid, cmd_angle, cmd_pulse, cmd_error, ack_tx_valid, ack_tx_data
    );

    modport slave (
        input  rx_valid, rx_data, ack_tx_ready,
        output cmd_valid, cmd_angle, cmd_pulse, cmd_error, ack_tx_valid, ack_tx_data
    );
endinterface

// File: rtl/uart_cmd_ack.sv
// Acknowledge sequencer: on start, presents 'A' then '\n' to the transmitter
// with a valid/ready handshake. A start while busy is ignored.
module uart_cmd_ack
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_uart,
    input  logic       start,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] data
);

    ack_state_t state;

    // Load 'A' on start, advance to '\n' then idle as each byte transfers.
    always_ff @(posedge clk or posedge reset_uart) begin
        if (reset_uart) begin
            state <= AckChar;
            valid <= 1'b0;
            data  <= 8'h00;
        end else if (!valid) begin
            if (start) begin
                state <= AckChar;
                valid <= 1'b1;
                data  <= CH_A;
            end
        end else if (ready) begin
            if (state == AckChar) begin
                state <= AckNewline;
                data  <= CH_LF;
            end else begin
                state <= AckChar;
                valid <= 1'b0;
                data  <= 8'h00;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART servo command parser: accepts frames "P<1-3 digits>\n", ignores '\r',
// and reports an angle plus the matching servo pulse width in clk cycles.
// Optional acknowledge transmission is enabled by defining UART_CMD_ACK_EN.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned MAX_ANGLE      = 180,
    parameter int unsigned PULSE_MIN_CYC  = 27000,
    parameter int unsigned PULSE_STEP_CYC = 150
) (
    input logic        clk,
    input logic        reset_uart,
    uart_cmd_if.slave  bus
);

    localparam logic [9:0]  max_acc   = 10'(MAX_ANGLE);
    localparam logic [15:0] pulse_rst = 16'(PULSE_MIN_CYC);

    state_t      state;
    logic [9:0]  acc;
    logic [1:0]  cnt;
    logic        cmd_valid;
    logic        cmd_error;
    logic [7:0]  cmd_angle;
    logic [15:0] cmd_pulse;

    logic [9:0]  acc_next;
    logic [15:0] pulse_next;

    // acc holds at most two digits when a third arrives, so 10 bits never overflow.
    assign acc_next   = 10'(acc * 10'd10) + {6'd0, bus.rx_data[3:0]};
    assign pulse_next = 16'(PULSE_MIN_CYC + 32'(acc) * PULSE_STEP_CYC);

    // Frame FSM with registered command outputs; strobes last one cycle.
    always_ff @(posedge clk or posedge reset_uart) begin
        if (reset_uart) begin
            state     <= StIdle;
            acc       <= '0;
            cnt       <= '0;
            cmd_valid <= 1'b0;
            cmd_error <= 1'b0;
            cmd_angle <= 8'd0;
            cmd_pulse <= pulse_rst;
        end else begin
            cmd_valid <= 1'b0;
            cmd_error <= 1'b0;
            if (bus.rx_valid && (bus.rx_data != CH_CR)) begin
                case (state)
                    StIdle: begin
                        if (bus.rx_data == CH_P) begin
                            state <= StDigits;
                            acc   <= '0;
                            cnt   <= '0;
                        end else if (bus.rx_data != CH_LF) begin
                            state <= StDiscard;
                        end
                    end
                    StDigits: begin
                        if (is_digit(bus.rx_data)) begin
                            if (cnt == 2'd3) begin
                                state <= StDiscard;
                            end else begin
                                acc <= acc_next;
                                cnt <= cnt + 2'd1;
                            end
                        end else if (bus.rx_data == CH_LF) begin
                            state <= StIdle;
                            if ((cnt != 2'd0) && (acc <= max_acc)) begin
                                cmd_valid <= 1'b1;
                                cmd_angle <= acc[7:0];
                                cmd_pulse <= pulse_next;
                            end else begin
                                cmd_error <= 1'b1;
                            end
                        end else begin
                            state <= StDiscard;
                        end
                    end
                    StDiscard: begin
                        if (bus.rx_data == CH_LF) begin
                            state     <= StIdle;
                            cmd_error <= 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_error = cmd_error;
    assign bus.cmd_angle = cmd_angle;
    assign bus.cmd_pulse = cmd_pulse;

`ifdef UART_CMD_ACK_EN
    logic       ack_valid;
    logic [7:0] ack_data;

    uart_cmd_ack u_ack (
        .clk        (clk),
        .reset_uart (reset_uart),
        .start      (cmd_valid),
        .ready      (bus.ack_tx_ready),
        .valid      (ack_valid),
        .data       (ack_data)
    );

    assign bus.ack_tx_valid = ack_valid;
    assign bus.ack_tx_data  = ack_data;
`else
    assign bus.ack_tx_valid = 1'b0;
    assign bus.ack_tx_data  = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a scoreboard of expected strobes.
module tb_uart_cmd_parser;

    typedef struct packed {
        logic        err;
        logic [7:0]  angle;
        logic [15:0] pulse;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_uart;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   last_angle = 0;
    exp_t sb[$];

    uart_cmd_if bus ();

    uart_cmd_parser #(
        .MAX_ANGLE      (180),
        .PULSE_MIN_CYC  (27000),
        .PULSE_STEP_CYC (150)
    ) dut (
        .clk        (clk),
        .reset_uart (reset_uart),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_pulse(input int a);
        return 16'(27000 + a * 150);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one byte for one cycle; optionally push the strobe it should cause.
    task automatic send_byte(input logic [7:0] b, input bit push, input exp_t e);
        exp_t t;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        if (push) begin
            t = e;
            t.cyc = cyc + 1;
            sb.push_back(t);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        exp_t none;
        none = '0;
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0, none);
    endtask

    // Send a frame whose final '\n' must produce one strobe.
    task automatic frame(input string s, input bit err, input int ang);
        exp_t e;
        exp_t none;
        none = '0;
        if (!err) last_angle = ang;
        e.err   = err;
        e.angle = 8'(last_angle);
        e.pulse = model_pulse(last_angle);
        e.cyc   = 0;
        for (int i = 0; i < s.len() - 1; i++) send_byte(s[i], 1'b0, none);
        send_byte(s[s.len() - 1], 1'b1, e);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset_uart && (bus.cmd_valid || bus.cmd_error)) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("cmd_error", bus.cmd_error, e.err);
                check("cmd_valid", bus.cmd_valid, !e.err);
                check("cmd_angle", bus.cmd_angle, e.angle);
                check("cmd_pulse", bus.cmd_pulse, e.pulse);
            end
        end
    end

    initial begin
        bus.rx_valid     = 1'b0;
        bus.rx_data      = 8'h00;
        bus.ack_tx_ready = 1'b1;
        reset_uart       = 1'b1;
        repeat (3) @(negedge clk);
        reset_uart = 1'b0;

        check("rst_angle", bus.cmd_angle, 0);
        check("rst_pulse", bus.cmd_pulse, 27000);
        check("rst_valid", bus.cmd_valid, 0);
        check("rst_error", bus.cmd_error, 0);
        check("rst_ack_valid", bus.ack_tx_valid, 0);
        check("rst_ack_data", bus.ack_tx_data, 0);

        frame("P90\n", 1'b0, 90);
        check("p90_pulse", bus.cmd_pulse, 40500);
        frame("P180\r\n", 1'b0, 180);
        check("p180_pulse", bus.cmd_pulse, 54000);
        frame("P0\n", 1'b0, 0);
        check("p0_pulse", bus.cmd_pulse, 27000);

        frame("P181\n", 1'b1, 0);
        frame("P1234\n", 1'b1, 0);
        frame("P\n", 1'b1, 0);
        frame("PX5\n", 1'b1, 0);
        send_str("\n\r");
        frame("Q7\n", 1'b1, 0);
        frame("P7P\n", 1'b1, 0);
        frame("P\r1\r2\r\n", 1'b0, 12);
        check("p12_angle", bus.cmd_angle, 12);

        // Reset in the middle of a frame.
        send_str("P4");
        #2 reset_uart = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_angle", bus.cmd_angle, 0);
        check("midrst_pulse", bus.cmd_pulse, 27000);
        reset_uart = 1'b0;
        last_angle = 0;
        frame("5\n", 1'b1, 0);
        frame("P45\n", 1'b0, 45);
        check("p45_angle", bus.cmd_angle, 45);
        frame("P999\n", 1'b1, 0);
        check("p999_keeps_angle", bus.cmd_angle, 45);
        check("p999_keeps_pulse", bus.cmd_pulse, 33750);
        repeat (6) @(negedge clk);

`ifdef UART_CMD_ACK_EN
        begin
            int n;
            int xfers;
            bit stable;
            logic [7:0] got[2];

            bus.ack_tx_ready = 1'b0;
            frame("P10\n", 1'b0, 10);
            n = 0;
            while (!bus.ack_tx_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("ack_valid_rise", bus.ack_tx_valid, 1);
            stable = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (!bus.ack_tx_valid || bus.ack_tx_data != 8'h41) stable = 1'b0;
            end
            check("ack_hold_stable", stable, 1);
            bus.ack_tx_ready = 1'b1;
            check("ack_byte0", bus.ack_tx_data, 8'h41);
            @(negedge clk);
            check("ack_byte1_valid", bus.ack_tx_valid, 1);
            check("ack_byte1", bus.ack_tx_data, 8'h0A);
            @(negedge clk);
            check("ack_done", bus.ack_tx_valid, 0);

            bus.ack_tx_ready = 1'b0;
            frame("P10\n", 1'b0, 10);
            frame("P20\n", 1'b0, 20);
            repeat (3) @(negedge clk);
            bus.ack_tx_ready = 1'b1;
            xfers = 0;
            got[0] = 8'h00;
            got[1] = 8'h00;
            repeat (12) begin
                if (bus.ack_tx_valid && bus.ack_tx_ready) begin
                    if (xfers < 2) got[xfers] = bus.ack_tx_data;
                    xfers++;
                end
                @(negedge clk);
            end
            check("ack_pair_count", xfers, 2);
            check("ack_pair_b0", got[0], 8'h41);
            check("ack_pair_b1", got[1], 8'h0A);
        end
`else
        begin
            bit seen;
            seen = 1'b0;
            bus.ack_tx_ready = 1'b1;
            frame("P33\n", 1'b0, 33);
            repeat (8) begin
                @(negedge clk);
                if (bus.ack_tx_valid || bus.ack_tx_data != 8'h00) seen = 1'b1;
            end
            check("ack_tied_off", seen, 0);
        end
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
